core_array_stream_mesh: RTL and testbench

- Parametrised ROWS x COLS successor of the fixed 2x2 core array.
- Each column is a chain of cells. Each cell holds one word plus fill/empty state and a mask counter.
- Words enter each column from the north through a valid/ready handshake, descend one row at a time, and leave from the south through a valid/ready handshake.
- New behaviour: a whole-array east-west rotate, a synchronous flush, and per-column occupancy reporting.

---
 rtl/core_array_pkg.sv | 15 +
 rtl/mesh_cell.sv | 75 +++++++
 rtl/core_array_stream_mesh.sv | 104 ++++++++++
 tb/tb_core_array_stream_mesh.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_array_pkg.sv
// Shared sizing helpers for the stream mesh and its cells.
package core_array_pkg;

  localparam int DATA_SIZE_DEF = 8;

  // Dwell counter needs at least one bit even when there is no dwell.
  function automatic int mask_cnt_width(input int delay);
    return ($clog2(delay + 1) > 1) ? $clog2(delay + 1) : 1;
  endfunction

  function automatic int occ_width(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/mesh_cell.sv
// One mesh cell: a word, its full flag and a dwell counter that must expire
// before the word may move on.
module mesh_cell
  import core_array_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int MASK_CNT_DELAY = 1,
  parameter int CW             = mask_cnt_width(MASK_CNT_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 rotate,
  input  logic                 rot_full,
  input  logic [DATA_SIZE-1:0] rot_data,
  input  logic [CW-1:0]        rot_cnt,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_data,
  input  logic                 rel,
  input  logic                 down_take,
  output logic                 full,
  output logic [DATA_SIZE-1:0] data,
  output logic [CW-1:0]        mask_cnt,
  output logic                 releasable,
  output logic                 accept
);

  logic                 full_q, full_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
    return (v != '0) ? v - CW'(1) : v;
  endfunction

  assign full       = full_q;
  assign data       = data_q;
  assign mask_cnt   = cnt_q;
  assign releasable = full_q && (cnt_q == '0);
  // A releasing cell can be refilled in the same cycle, keeping the column pipelined.
  assign accept     = !(flush || rotate) && (!full_q || (releasable && down_take));

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = dec(cnt_q);
    if (flush) begin
      full_d = 1'b0;
      cnt_d  = '0;
    end else if (rotate) begin
      full_d = rot_full;
      data_d = rot_data;
      cnt_d  = dec(rot_cnt);
    end else if (load) begin
      full_d = 1'b1;
      data_d = load_data;
      cnt_d  = CW'(MASK_CNT_DELAY);
    end else if (rel) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/core_array_stream_mesh.sv
// ROWS x COLS grid of mesh cells: words descend each column under valid/ready,
// with whole-array east rotate, flush and per-column occupancy.
module core_array_stream_mesh
  import core_array_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int ROWS           = 2,
  parameter int COLS           = 2,
  parameter int MASK_CNT_DELAY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COLS-1:0]                     i_valid,
  output logic [COLS-1:0]                     i_ready,
  input  logic [COLS*DATA_SIZE-1:0]           i_data,
  output logic [COLS-1:0]                     o_valid,
  input  logic [COLS-1:0]                     o_ready,
  output logic [COLS*DATA_SIZE-1:0]           o_data,
  input  logic                                flush,
  input  logic                                ew_shift,
  output logic [COLS*occ_width(ROWS)-1:0]     occupancy
);

  localparam int CW = mask_cnt_width(MASK_CNT_DELAY);
  localparam int OW = occ_width(ROWS);

  logic                 full_a [COLS][ROWS];
  logic [DATA_SIZE-1:0] data_a [COLS][ROWS];
  logic [CW-1:0]        cnt_a  [COLS][ROWS];
  logic                 rls_a  [COLS][ROWS];
  logic                 hold;
  logic [OW-1:0]        pop_cnt;

  assign hold = flush | ew_shift;

  for (genvar c = 0; c < COLS; c++) begin : gen_col
    localparam int SRC = (c + COLS - 1) % COLS;

    for (genvar r = 0; r < ROWS; r++) begin : gen_row
      logic                 acc;
      logic                 down_take;
      logic                 load;
      logic                 mv;
      logic [DATA_SIZE-1:0] load_data;

      // Ready chain runs south to north within the column.
      if (r == ROWS - 1) begin : g_south
        assign down_take = o_valid[c] & o_ready[c];
      end else begin : g_inner
        assign down_take = gen_row[r+1].acc;
      end

      if (r == 0) begin : g_north
        assign load      = i_valid[c] & acc;
        assign load_data = i_data[c*DATA_SIZE +: DATA_SIZE];
      end else begin : g_chain
        assign load      = gen_row[r-1].mv;
        assign load_data = data_a[c][r-1];
      end

      assign mv = rls_a[c][r] & down_take;

      mesh_cell #(
        .DATA_SIZE      (DATA_SIZE),
        .MASK_CNT_DELAY (MASK_CNT_DELAY),
        .CW             (CW)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rotate     (ew_shift),
        .rot_full   (full_a[SRC][r]),
        .rot_data   (data_a[SRC][r]),
        .rot_cnt    (cnt_a[SRC][r]),
        .load       (load),
        .load_data  (load_data),
        .rel        (mv),
        .down_take  (down_take),
        .full       (full_a[c][r]),
        .data       (data_a[c][r]),
        .mask_cnt   (cnt_a[c][r]),
        .releasable (rls_a[c][r]),
        .accept     (acc)
      );
    end

    assign i_ready[c]                        = gen_row[0].acc;
    assign o_valid[c]                        = rls_a[c][ROWS-1] & ~hold;
    assign o_data[c*DATA_SIZE +: DATA_SIZE]  = data_a[c][ROWS-1];
  end

  always_comb begin
    occupancy = '0;
    pop_cnt   = '0;
    for (int c = 0; c < COLS; c++) begin
      pop_cnt = '0;
      for (int r = 0; r < ROWS; r++) begin
        pop_cnt = pop_cnt + OW'(full_a[c][r]);
      end
      occupancy[c*OW +: OW] = pop_cnt;
    end
  end

endmodule

// File: tb/tb_core_array_stream_mesh.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks
// every south-side handshake; directed checks cover reset, rotate and flush.
module tb_core_array_stream_mesh;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  i_valid, i_ready, o_valid, o_ready;
  logic [15:0] i_data, o_data;
  logic        flush, ew_shift;
  logic [3:0]  occupancy;

  logic        fr_i_valid, fr_i_ready, fr_o_valid, fr_o_ready;
  logic [7:0]  fr_i_data, fr_o_data;
  logic [2:0]  fr_occ;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] frq[$];
  int         frt[$];
  int last0 = -100;
  int last1 = -100;
  int fr_last = -100;

  core_array_stream_mesh #(.DATA_SIZE(8), .ROWS(2), .COLS(2), .MASK_CNT_DELAY(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .flush(flush), .ew_shift(ew_shift), .occupancy(occupancy)
  );

  core_array_stream_mesh #(.DATA_SIZE(8), .ROWS(4), .COLS(1), .MASK_CNT_DELAY(0)) dut_fr (
    .clk(clk), .rst(rst), .i_valid(fr_i_valid), .i_ready(fr_i_ready), .i_data(fr_i_data),
    .o_valid(fr_o_valid), .o_ready(fr_o_ready), .o_data(fr_o_data),
    .flush(1'b0), .ew_shift(1'b0), .occupancy(fr_occ)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input logic [7:0] d, input bit push, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    tick();
    i_data[c*8 +: 8] = d;
    i_valid[c]       = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (i_ready[c]) begin
        ok = 1'b1;
        t  = cyc;
        if (push) begin
          if (c == 0) q0.push_back(d);
          else        q1.push_back(d);
        end
      end
      tick();
    end
    i_valid[c] = 1'b0;
    if (!ok) fail("send_timeout");
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] w;
      if (o_valid[0] && o_ready[0]) begin
        if (q0.size() == 0) fail("unexpected_out_col0");
        else begin
          w = q0.pop_front();
          chk("out_data_col0", o_data[7:0], w);
          chk("out_gap_col0", (cyc - last0) >= 2, 1);
          last0 = cyc;
        end
      end
      if (o_valid[1] && o_ready[1]) begin
        if (q1.size() == 0) fail("unexpected_out_col1");
        else begin
          w = q1.pop_front();
          chk("out_data_col1", o_data[15:8], w);
          chk("out_gap_col1", (cyc - last1) >= 2, 1);
          last1 = cyc;
        end
      end
      if (fr_o_valid && fr_o_ready) begin
        if (frq.size() == 0) fail("unexpected_out_fr");
        else begin
          w = frq.pop_front();
          chk("fr_data", fr_o_data, w);
          chk("fr_latency", cyc - frt.pop_front(), 4);
          if (fr_last >= 0) chk("fr_gap", cyc - fr_last, 1);
          fr_last = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bit found;
    rst = 1'b1; i_valid = '0; i_data = '0; o_ready = '0; flush = 1'b0; ew_shift = 1'b0;
    fr_i_valid = 1'b0; fr_i_data = '0; fr_o_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 2'b00);
    chk("rst_occupancy", occupancy, 4'h0);
    chk("rst_o_data", o_data, 16'h0000);
    chk("rst_i_ready", i_ready, 2'b11);

    // Three words in flight, then a mid-stream reset
    tick();
    i_data = 16'h3231; i_valid = 2'b11;
    tick();
    i_valid = 2'b01; i_data[7:0] = 8'h33;
    repeat (6) tick();
    i_valid = 2'b00;
    @(negedge clk);
    chk("inflight_occupancy", occupancy, 4'b0110);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_o_valid", o_valid, 2'b00);
    chk("midrst_occupancy", occupancy, 4'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_i_ready", i_ready, 2'b11);

    // Single-word latency
    o_ready = 2'b11;
    send(0, 8'hA5, 1'b1, t);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (o_valid[0]) found = 1'b1;
    end
    if (!found) fail("latency_timeout");
    else begin
      chk("latency_a5", cyc - t, 4);
      chk("odata_a5", o_data[7:0], 8'hA5);
      chk("col1_idle", o_valid[1], 1'b0);
    end

    // Backpressure on column 1
    tick();
    o_ready = 2'b01;
    send(1, 8'h01, 1'b1, t);
    send(1, 8'h02, 1'b1, t);
    repeat (5) tick();
    @(negedge clk);
    chk("bp_i_ready", i_ready[1], 1'b0);
    chk("bp_occupancy", occupancy[3:2], 2'd2);
    tick();
    o_ready = 2'b11;
    send(1, 8'h03, 1'b1, t);
    repeat (15) tick();

    // East rotate
    o_ready = 2'b00;
    i_data = 16'h2211; i_valid = 2'b11;
    @(negedge clk);
    chk("rot_load_ready", i_ready, 2'b11);
    tick();
    i_valid = 2'b00;
    repeat (5) tick();
    @(negedge clk);
    chk("rot_pre_valid", o_valid, 2'b11);
    chk("rot_pre_occ", occupancy, 4'b0101);
    tick();
    ew_shift = 1'b1;
    @(negedge clk);
    chk("rot_shift_o_valid", o_valid, 2'b00);
    chk("rot_shift_i_ready", i_ready, 2'b00);
    tick();
    ew_shift = 1'b0;
    @(negedge clk);
    chk("rot_o_data", o_data, 16'h1122);
    chk("rot_o_valid", o_valid, 2'b11);

    // Flush dominates rotate and loads
    tick();
    flush = 1'b1; ew_shift = 1'b1; i_valid = 2'b11; i_data = 16'h8877;
    @(negedge clk);
    chk("flush_i_ready", i_ready, 2'b00);
    chk("flush_o_valid", o_valid, 2'b00);
    tick();
    flush = 1'b0; ew_shift = 1'b0; i_valid = 2'b00;
    @(negedge clk);
    chk("flush_occupancy", occupancy, 4'h0);
    chk("flush_no_rotate", o_data, 16'h1122);
    chk("flush_post_valid", o_valid, 2'b00);
    tick();
    o_ready = 2'b11;
    @(negedge clk);
    chk("flush_post_ready", i_ready, 2'b11);

    // Full-rate stream on the 4-row, zero-dwell instance
    tick();
    for (int i = 0; i < 12; i++) begin
      fr_i_data  = 8'h40 + 8'(i);
      fr_i_valid = 1'b1;
      @(negedge clk);
      chk("fr_i_ready", fr_i_ready, 1'b1);
      if (fr_i_ready) begin
        frq.push_back(fr_i_data);
        frt.push_back(cyc);
      end
      tick();
    end
    fr_i_valid = 1'b0;

    for (int k = 0; k < 30 && (q0.size() + q1.size() + frq.size()) != 0; k++) tick();
    repeat (2) tick();
    chk("drain_col0", q0.size(), 0);
    chk("drain_col1", q1.size(), 0);
    chk("drain_fr", frq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
